// File: rtl/clken_gen_pkg.sv
// Shared types and helpers for the clken_gen_multi clock-enable generator.
// Defining CLKGEN_DUTY_EN adds a programmable high-time field to the channel config.
package clken_gen_pkg;

    // Internal config field width; DIV_W of the generator must not exceed CFG_W-2.
    localparam int CFG_W = 32;

    typedef enum logic [1:0] {
        S_LOAD,
        S_SETTLE,
        S_LOCKED
    } state_t;

    typedef struct packed {
        logic [CFG_W-1:0] div;
        logic [CFG_W-1:0] phase;
`ifdef CLKGEN_DUTY_EN
        logic [CFG_W-1:0] high;
`endif
    } ch_cfg_t;

    // Phase must already be clamped to div.
    function automatic logic [CFG_W-1:0] load_value(input logic [CFG_W-1:0] div,
                                                    input logic [CFG_W-1:0] phase);
        return (phase == '0) ? '0 : div + CFG_W'(1) - phase;
    endfunction

    function automatic logic [CFG_W-1:0] default_high(input logic [CFG_W-1:0] div);
        return (div + CFG_W'(2)) >> 1;
    endfunction

endpackage

// File: rtl/clken_gen_ch.sv
// One clock-enable channel: counter preset on load, free-running wrap at div,
// enable strobe at count 0 and divided level while count < high time.
module clken_gen_ch
    import clken_gen_pkg::*;
#(
    parameter int DIV_W   = 16,
    parameter int DEF_DIV = 19
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_load,
    input  logic    i_run,
    input  ch_cfg_t i_cfg,
    output logic    o_outclk,
    output logic    o_clken
);

    localparam logic [CFG_W-1:0] DEF_DIV_W  = CFG_W'(DEF_DIV);
    localparam logic [CFG_W-1:0] DEF_HIGH_W = default_high(DEF_DIV_W);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W:0]   r_high;
    logic [CFG_W-1:0] w_load_full;
    logic [CFG_W-1:0] w_high_full;
    logic             w_unused;

    assign w_load_full = load_value(i_cfg.div, i_cfg.phase);
`ifdef CLKGEN_DUTY_EN
    assign w_high_full = i_cfg.high;
`else
    assign w_high_full = default_high(i_cfg.div);
`endif

    // Upper config bits are zero by construction and are intentionally dropped.
    assign w_unused = ^{i_cfg.div[CFG_W-1:DIV_W], w_load_full[CFG_W-1:DIV_W],
                        w_high_full[CFG_W-1:DIV_W+1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_div  <= DEF_DIV_W[DIV_W-1:0];
            r_high <= DEF_HIGH_W[DIV_W:0];
        end else if (i_load) begin
            r_div  <= i_cfg.div[DIV_W-1:0];
            r_high <= w_high_full[DIV_W:0];
            r_cnt  <= w_load_full[DIV_W-1:0];
        end else if (i_run) begin
            r_cnt <= (r_cnt == r_div) ? '0 : r_cnt + DIV_W'(1);
        end
    end

    assign o_clken  = i_run && (r_cnt == '0);
    assign o_outclk = i_run && ({1'b0, r_cnt} < r_high);

endmodule

// File: rtl/clken_gen_multi.sv
// Multi-channel clock-enable generator: per-channel shadow config, apply/lock FSM.
// Optional CLKGEN_DUTY_EN adds cfg_high for a programmable per-channel high time.
module clken_gen_multi
    import clken_gen_pkg::*;
#(
    parameter int NUM_CH   = 5,
    parameter int DIV_W    = 16,
    parameter int DEF_DIV  = 19,
    parameter int LOCK_CYC = 64,
    parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
`ifdef CLKGEN_DUTY_EN
    input  logic [DIV_W-1:0]  cfg_high,
`endif
    input  logic              cfg_apply,
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] clken,
    output logic              locked
);

    localparam int               LK_W      = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
    localparam logic [CFG_W-1:0] DEF_DIV_W = CFG_W'(DEF_DIV);

    state_t          r_state;
    state_t          w_state_next;
    logic [LK_W-1:0] r_settle;
    logic            w_load;
    logic            w_run;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_LOAD;
            r_settle <= '0;
        end else begin
            r_state  <= w_state_next;
            r_settle <= (r_state == S_SETTLE) ? r_settle + LK_W'(1) : '0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_run        = 1'b0;
        locked       = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_load       = 1'b1;
                w_state_next = S_SETTLE;
            end
            S_SETTLE: begin
                w_run = 1'b1;
                if (r_settle == LK_W'(LOCK_CYC - 1))
                    w_state_next = S_LOCKED;
            end
            S_LOCKED: begin
                w_run  = 1'b1;
                locked = 1'b1;
            end
            default: w_state_next = S_LOAD;
        endcase
        // Apply wins from any state; a write in the same cycle is already in the shadow by then.
        if (cfg_apply)
            w_state_next = S_LOAD;
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        ch_cfg_t r_shadow;
        ch_cfg_t w_commit;

        always_ff @(posedge refclk or negedge rst_n) begin
            if (!rst_n) begin
                r_shadow.div   <= DEF_DIV_W;
                r_shadow.phase <= '0;
`ifdef CLKGEN_DUTY_EN
                r_shadow.high  <= default_high(DEF_DIV_W);
`endif
            end else if (cfg_we && (cfg_ch == CH_W'(gi))) begin
                r_shadow.div   <= CFG_W'(cfg_div);
                r_shadow.phase <= CFG_W'(cfg_phase);
`ifdef CLKGEN_DUTY_EN
                r_shadow.high  <= CFG_W'(cfg_high);
`endif
            end
        end

        always_comb begin
            w_commit = r_shadow;
            if (r_shadow.phase > r_shadow.div)
                w_commit.phase = r_shadow.div;
`ifdef CLKGEN_DUTY_EN
            if (r_shadow.high == '0)
                w_commit.high = CFG_W'(1);
            else if (r_shadow.high > r_shadow.div + CFG_W'(1))
                w_commit.high = r_shadow.div + CFG_W'(1);
`endif
        end

        clken_gen_ch #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk      (refclk),
            .rst_n    (rst_n),
            .i_load   (w_load),
            .i_run    (w_run),
            .i_cfg    (w_commit),
            .o_outclk (outclk[gi]),
            .o_clken  (clken[gi])
        );
    end

endmodule
